data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Misses stall the CPU while the victim line is written back (if dirty) and the new line is refilled.
module data_cache #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic         cpu_byte,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t               r_state;
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];

  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [127:0]         r_mem_wdata;

  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_index;
  logic [1:0]           w_word;
  logic [1:0]           w_byte;
  logic [127:0]         w_line;
  logic [31:0]          w_word_data;
  logic [7:0]           w_byte_data;
  logic                 w_hit;
  logic                 w_idle_req;
  logic                 w_load_hit;
  logic                 w_store_hit;
  logic                 w_miss;
  logic                 w_install;

  assign w_tag   = cpu_addr[31:4+IDX_W];
  assign w_index = cpu_addr[4+IDX_W-1:4];
  assign w_word  = cpu_addr[3:2];
  assign w_byte  = cpu_addr[1:0];

  assign w_line      = r_data[w_index];
  assign w_word_data = w_line[{w_word, 5'b00000} +: 32];
  assign w_byte_data = w_word_data[{w_byte, 3'b000} +: 8];

  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_idle_req  = (r_state == IDLE) && cpu_req;
  assign w_load_hit  = w_idle_req && w_hit && !cpu_we;
  assign w_store_hit = w_idle_req && w_hit && cpu_we;
  assign w_miss      = w_idle_req && !w_hit;
  assign w_install   = (r_state == REFILL) && mem_ack;

  // Hits answer in the same cycle; anything outside IDLE keeps the pipeline frozen.
  assign cpu_stall = (r_state != IDLE) || w_miss;
  assign cpu_rdata = !w_load_hit ? 32'h0 :
                     cpu_byte    ? {24'h0, w_byte_data} : w_word_data;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Memory-side request is registered on entry to each transfer state, so it holds until mem_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 128'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_store_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
          if (w_miss) begin
            r_mem_req <= 1'b1;
            if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state     <= WRITEBACK;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_index], w_index, 4'b0000};
              r_mem_wdata <= w_line;
            end else begin
              r_state    <= REFILL;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_index, 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            r_state    <= REFILL;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_index, 4'b0000};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_state          <= IDLE;
            r_mem_req        <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_install) begin
        r_data[w_index] <= mem_rdata;
        r_tag[w_index]  <= w_tag;
      end else if (w_store_hit) begin
        if (cpu_byte) begin
          r_data[w_index][{w_word, w_byte, 3'b000} +: 8] <= cpu_wdata[7:0];
        end else begin
          r_data[w_index][{w_word, 5'b00000} +: 32] <= cpu_wdata;
        end
      end
    end
  end

endmodule
